counter_updown_mod: RTL
=======================

// Module: counter_updown_mod
// PURPOSE
//  Parametrised modulo-N up/down counter; successor of the basic free-running WIDTH counter.
//  Adds direction control, runtime modulus, synchronous load, and wrap/saturate mode.
//  Adds carry/borrow pulses for cascading and terminal flags.
//  Used as a timebase / event counter in lab datapaths; carry of one stage may drive en of the next.
// PARAMETERS
//  WIDTH      8   counter width in bits (>=2)
//  RESET_VAL  0   count value after reset; must be <= any max_val used
// PORTS
//  clk       in   1      single clock, all state updates on posedge
//  reset     in   1      synchronous, active-high; overrides every other input
//  en        in   1      count enable, active-high; 0 = hold count
//  up_dn     in   1      1 = count up, 0 = count down; sampled only when en=1
//  mode      in   1      0 = WRAP, 1 = SAT (saturate at bounds)
//  load      in   1      synchronous load strobe, active-high
//  load_val  in   WIDTH  value loaded when load=1
//  max_val   in   WIDTH  terminal value; legal range 0..max_val
//  count     out  WIDTH  registered count
//  carry     out  1      registered 1-cycle pulse: up-count terminal event
//  borrow    out  1      registered 1-cycle pulse: down-count terminal event
//  at_max    out  1      level flag: count >= max_val (combinational from registered count)
//  at_min    out  1      level flag: count == 0 (combinational from registered count)
// BEHAVIOUR
//  - Priority per edge: reset > load > en > hold.
//  - reset=1: count<=RESET_VAL; carry<=0; borrow<=0.
//  - load=1: count<=min(load_val,max_val); carry<=0; borrow<=0; en ignored this cycle.
//  - en=0: count holds; carry<=0; borrow<=0 (pulses never stretch).
//  - en=1, up_dn=1, count<max_val: count<=count+1; carry<=0.
//  - en=1, up_dn=1, count>=max_val:
//      WRAP: count<=0; carry<=1.
//      SAT:  count<=max_val; carry<=1 only if count!=max_val or on the first terminal
//            step after a non-terminal cycle (one pulse per arrival).
//  - en=1, up_dn=0, count>0: count<=count-1; borrow<=0.
//  - en=1, up_dn=0, count==0:
//      WRAP: count<=max_val; borrow<=1.
//      SAT:  count<=0; borrow<=1 once per arrival, as for carry.
//  - carry and borrow are never both 1.
//  - Latency: count/carry/borrow change 1 clk after the qualifying edge; flags follow count.
//  - max_val lowered below count: the next up step is terminal (WRAP->0, SAT->max_val).
//    A down step decrements normally.
//  - max_val=0: count stays 0. Every enabled step is terminal:
//      WRAP: carry/borrow pulse each step.
//      SAT:  carry/borrow pulse once per arrival.
//  - Direction or mode change takes effect on the same edge it is sampled.
//    No pipeline, no pending state.
//  - Arithmetic is unsigned modulo 2^WIDTH internally; the compare uses >= so wrap never
//    exceeds max_val.
//  - SAT arrival tracking: a 1-bit "was_terminal" register per direction.
//    Cleared by reset, load, and any non-terminal step.
// STRUCTURE
//  - Shared package: localparams MODE_WRAP=1'b0, MODE_SAT=1'b1, DIR_DOWN=1'b0, DIR_UP=1'b1.
//  - Single flat module: next-state mux + terminal compare.
//  - No sub-module; the terminal comparator is inline.
// TESTING
//  1. WIDTH=4, max_val=9, WRAP, up, en=1 from reset:
//     count 0..9,0; carry=1 only in the cycle count returns to 0.
//  2. Down WRAP, max_val=9, count=0, en=1: count->9, borrow=1 one cycle, then 8,7.
//  3. SAT up, max_val=5, en held 10 cycles:
//     count sticks at 5; carry pulses exactly once; at_max=1 from count=5.
//  4. load=1, load_val=12, max_val=9, en=1 same cycle: count->9, no carry, count not incremented.
//  5. Counting mid-run at count=7, reset=1 with load=1 and en=1: count->RESET_VAL=0; carry=borrow=0.
//  6. max_val lowered 9->3 while count=7, up WRAP en=1: next count=0, carry=1.
//     Then en=0 for 3 cycles: count holds 0, carry=0.

Source files
------------

// File: rtl/counter_updown_mod_pkg.sv
// Shared constants for the modulo-N up/down counter: mode and direction encodings.
package counter_updown_mod_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

endpackage : counter_updown_mod_pkg

// File: rtl/counter_updown_mod.sv
// Modulo-N up/down counter with runtime modulus, synchronous load, wrap/saturate mode,
// cascadable carry/borrow pulses and terminal level flags.
module counter_updown_mod
  import counter_updown_mod_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic [WIDTH-1:0] count_nxt;
  logic             carry_nxt;
  logic             borrow_nxt;
  logic             was_term_up;
  logic             was_term_up_nxt;
  logic             was_term_dn;
  logic             was_term_dn_nxt;
  logic             up_term_c;
  logic             dn_term_c;

  // >= keeps a lowered max_val from letting the count run past the modulus
  assign up_term_c = (count >= max_val);
  assign dn_term_c = (count == '0);

  assign at_max = up_term_c;
  assign at_min = dn_term_c;

  // Next-state mux: load > en > hold; reset is applied in the register block
  always_comb begin
    count_nxt       = count;
    carry_nxt       = 1'b0;
    borrow_nxt      = 1'b0;
    was_term_up_nxt = was_term_up;
    was_term_dn_nxt = was_term_dn;

    if (load) begin
      count_nxt       = (load_val > max_val) ? max_val : load_val;
      was_term_up_nxt = 1'b0;
      was_term_dn_nxt = 1'b0;
    end else if (en) begin
      was_term_up_nxt = 1'b0;
      was_term_dn_nxt = 1'b0;
      case (up_dn)
        DIR_UP: begin
          if (!up_term_c) begin
            count_nxt = count + ONE;
          end else begin
            was_term_up_nxt = 1'b1;
            if (mode == MODE_SAT) begin
              count_nxt = max_val;
              carry_nxt = (count != max_val) || !was_term_up;
            end else begin
              count_nxt = '0;
              carry_nxt = 1'b1;
            end
          end
        end
        DIR_DOWN: begin
          if (!dn_term_c) begin
            count_nxt = count - ONE;
          end else begin
            was_term_dn_nxt = 1'b1;
            if (mode == MODE_WRAP) begin
              count_nxt  = max_val;
              borrow_nxt = 1'b1;
            end else begin
              count_nxt  = '0;
              borrow_nxt = !was_term_dn;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= RST_COUNT;
      carry       <= 1'b0;
      borrow      <= 1'b0;
      was_term_up <= 1'b0;
      was_term_dn <= 1'b0;
    end else begin
      count       <= count_nxt;
      carry       <= carry_nxt;
      borrow      <= borrow_nxt;
      was_term_up <= was_term_up_nxt;
      was_term_dn <= was_term_dn_nxt;
    end
  end

endmodule : counter_updown_mod
